// File: rtl/even_odd_seq_checker.sv
// even_odd_seq_checker
//
// Watches the 4-bit output of an even/odd up/down counter. It checks that
// every sample has the selected parity and that successive samples move by
// exactly +2 or -2 (mod 16) in one constant direction. The block acquires
// lock, infers the direction, flags violations and keeps a saturating count
// of errors.
//
// Parameters
//   LOCK_LEN  consecutive legal steps after the reference sample needed to lock (1..7)
//   ERR_W     width of the saturating error counter
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   valid       count carries a sample this cycle
//   count       counter value under test
//   even        expected parity: 1 = even, 0 = odd
//   locked      level: the sequence is acquired and being tracked
//   dir         inferred direction: 1 = up (+2), 0 = down (-2)
//   wrap        pulse: a legal tracked step crossed the 4-bit boundary
//   err_parity  pulse: the sample had the wrong parity
//   err_step    pulse: an illegal step while tracking or locked
//   err_count   saturating count of error cycles
//
// All outputs are registered and respond one cycle after the sampling edge.
module even_odd_seq_checker #(
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [3:0]       count,
  input  logic             even,
  output logic             locked,
  output logic             dir,
  output logic             wrap,
  output logic             err_parity,
  output logic             err_step,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_TRACK,
    S_LOCKED
  } state_t;

  localparam logic [2:0] LOCK_LEN_C = 3'(LOCK_LEN);

  state_t           state_q;
  logic [3:0]       ref_q;
  logic [2:0]       run_q;
  logic             dir_q;
  logic             locked_q;
  logic             wrap_q;
  logic             err_parity_q;
  logic             err_step_q;
  logic [ERR_W-1:0] err_count_q;

  logic [3:0]       delta;
  logic             parity_ok;
  logic             step_up;
  logic             step_dn;
  logic             step_fwd;
  logic             wrap_d;
  logic [2:0]       run_d;
  logic [ERR_W-1:0] err_count_d;

  // Even parity means bit 0 must be clear.
  assign parity_ok = (count[0] != even);

  // Modular difference; 2 is a legal up-step and 14 a legal down-step.
  assign delta    = count - ref_q;
  assign step_up  = (delta == 4'd2);
  assign step_dn  = (delta == 4'd14);
  assign step_fwd = dir_q ? step_up : step_dn;

  // A legal step in the tracked direction wraps when the value moves "backwards"
  // numerically: 14->0 or 15->1 going up, 0->14 or 1->15 going down.
  assign wrap_d = dir_q ? (count < ref_q) : (count > ref_q);

  assign run_d       = run_q + 3'd1;
  assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + ERR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ref_q        <= 4'd0;
      run_q        <= 3'd0;
      dir_q        <= 1'b0;
      locked_q     <= 1'b0;
      wrap_q       <= 1'b0;
      err_parity_q <= 1'b0;
      err_step_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      wrap_q       <= 1'b0;
      err_parity_q <= 1'b0;
      err_step_q   <= 1'b0;
      if (valid) begin
        if (!parity_ok) begin
          // Wrong parity wins over any step evaluation and is never a reference.
          err_parity_q <= 1'b1;
          err_count_q  <= err_count_d;
          locked_q     <= 1'b0;
          state_q      <= S_IDLE;
        end else begin
          ref_q <= count;
          case (state_q)
            S_IDLE: begin
              state_q <= S_ACQUIRE;
            end
            S_ACQUIRE: begin
              // Illegal steps here only re-seed the reference, silently.
              if (step_up || step_dn) begin
                dir_q <= step_up;
                run_q <= 3'd1;
                if (LOCK_LEN == 1) begin
                  state_q  <= S_LOCKED;
                  locked_q <= 1'b1;
                end else begin
                  state_q <= S_TRACK;
                end
              end
            end
            S_TRACK: begin
              if (step_fwd) begin
                run_q  <= run_d;
                wrap_q <= wrap_d;
                if (run_d == LOCK_LEN_C) begin
                  state_q  <= S_LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                err_step_q  <= 1'b1;
                err_count_q <= err_count_d;
                state_q     <= S_ACQUIRE;
              end
            end
            S_LOCKED: begin
              if (step_fwd) begin
                wrap_q <= wrap_d;
              end else begin
                err_step_q  <= 1'b1;
                err_count_q <= err_count_d;
                locked_q    <= 1'b0;
                state_q     <= S_ACQUIRE;
              end
            end
            default: begin
              state_q <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign locked     = locked_q;
  assign dir        = dir_q;
  assign wrap       = wrap_q;
  assign err_parity = err_parity_q;
  assign err_step   = err_step_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_even_odd_seq_checker.sv
// Testbench for even_odd_seq_checker: a default instance (ERR_W=8) and a
// narrow-counter instance (ERR_W=2) share the same stimulus. Expected values
// come from a streak-based reference model of the sequence rules.
module tb_even_odd_seq_checker;

  localparam int LOCK_LEN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] count = 4'd0;
  logic       even = 1'b1;

  logic       locked_a, dir_a, wrap_a, ep_a, es_a;
  logic [7:0] ec_a;
  logic       locked_b, dir_b, wrap_b, ep_b, es_b;
  logic [1:0] ec_b;

  even_odd_seq_checker #(.LOCK_LEN(LOCK_LEN), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .valid(valid), .count(count), .even(even),
    .locked(locked_a), .dir(dir_a), .wrap(wrap_a),
    .err_parity(ep_a), .err_step(es_a), .err_count(ec_a)
  );

  even_odd_seq_checker #(.LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .valid(valid), .count(count), .even(even),
    .locked(locked_b), .dir(dir_b), .wrap(wrap_b),
    .err_parity(ep_b), .err_step(es_b), .err_count(ec_b)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {locked_a, dir_a, wrap_a, ep_a, es_a, ec_a,
                locked_b, dir_b, wrap_b, ep_b, es_b, ec_b};

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: "streak" is the number of consecutive legal steps in one
  // direction ending at the last good sample; locked means streak >= LOCK_LEN.
  int m_have, m_ref, m_streak, m_cnt;
  bit m_dir, m_wrap, m_perr, m_serr;

  task automatic model_reset();
    m_have = 0; m_ref = 0; m_streak = 0; m_cnt = 0;
    m_dir = 0; m_wrap = 0; m_perr = 0; m_serr = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit e);
    bit up, dn;
    m_wrap = 0; m_perr = 0; m_serr = 0;
    if (v) begin
      if ((c % 2) != (e ? 0 : 1)) begin
        m_perr = 1; m_cnt++; m_have = 0; m_streak = 0;
      end else if (m_have == 0) begin
        m_have = 1; m_ref = c;
      end else begin
        up = ((m_ref + 2) % 16) == c;
        dn = ((m_ref + 14) % 16) == c;
        if (m_streak == 0) begin
          if (up || dn) begin m_streak = 1; m_dir = up; end
        end else if (m_dir ? up : dn) begin
          m_streak++;
          m_wrap = m_dir ? (m_ref >= 14) : (m_ref <= 1);
        end else begin
          m_serr = 1; m_cnt++; m_streak = 0;
        end
        m_ref = c;
      end
    end
  endtask

  function automatic logic [19:0] exp_vec();
    logic [7:0] s8;
    logic [1:0] s2;
    logic       lk;
    s8 = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
    s2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    lk = (m_streak >= LOCK_LEN);
    return {lk, m_dir, m_wrap, m_perr, m_serr, s8, lk, m_dir, m_wrap, m_perr, m_serr, s2};
  endfunction

  task automatic drive(input bit v, input int c, input bit e);
    valid = v; count = 4'(c); even = e;
    @(posedge clk);
    model_step(v, c, e);
    #1;
  endtask

  // Holds reset for one edge while presenting a valid sample, which must be ignored.
  task automatic do_reset();
    reset = 1'b0; valid = 1'b1; count = 4'($urandom_range(0, 15));
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b1; valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (obs !== 20'd0) $display("FAIL reset_state: got %h expected %h", obs, 20'd0);
    else n_pass++;
  endtask

  task automatic test_lock_up();
    int seq[5] = '{0, 2, 4, 6, 8};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, seq[i], 1);
      n_total++;
      if (obs !== exp_vec()) $display("FAIL lock_up_model[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if (locked_a !== 1'b0) $display("FAIL lock_up_early: locked got %b expected 0", locked_a);
        else n_pass++;
      end
    end
    n_total++;
    if ({locked_a, dir_a, ec_a} !== {1'b1, 1'b1, 8'd0})
      $display("FAIL lock_up_final: got locked=%b dir=%b errs=%0d expected 1 1 0", locked_a, dir_a, ec_a);
    else n_pass++;
  endtask

  task automatic test_wrap_down();
    int seq[6] = '{7, 5, 3, 1, 15, 13};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, seq[i], 0);
      n_total++;
      if (obs !== exp_vec()) $display("FAIL wrap_down_model[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      n_total++;
      if (wrap_a !== ((i == 4) ? 1'b1 : 1'b0)) $display("FAIL wrap_down_pulse[%0d]: got %b expected %b", i, wrap_a, (i == 4));
      else n_pass++;
    end
    n_total++;
    if ({locked_a, dir_a, ec_a} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL wrap_down_final: got locked=%b dir=%b errs=%0d expected 1 0 0", locked_a, dir_a, ec_a);
    else n_pass++;
  endtask

  task automatic test_step_error();
    int seq[6] = '{2, 4, 6, 10, 12, 14};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, seq[i], 1);
      n_total++;
      if (obs !== exp_vec()) $display("FAIL step_err_model[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 3) begin
        n_total++;
        if ({es_a, locked_a, ec_a} !== {1'b1, 1'b0, 8'd1})
          $display("FAIL step_err_hit: got err_step=%b locked=%b errs=%0d expected 1 0 1", es_a, locked_a, ec_a);
        else n_pass++;
      end
    end
    n_total++;
    if (locked_a !== 1'b1) $display("FAIL step_err_relock: locked got %b expected 1", locked_a);
    else n_pass++;
  endtask

  task automatic test_parity();
    int seq[6] = '{4, 6, 7, 8, 10, 12};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, seq[i], 1);
      n_total++;
      if (obs !== exp_vec()) $display("FAIL parity_model[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 2) begin
        n_total++;
        if ({ep_a, es_a, locked_a} !== 3'b100)
          $display("FAIL parity_hit: got perr=%b serr=%b locked=%b expected 1 0 0", ep_a, es_a, locked_a);
        else n_pass++;
      end
    end
    n_total++;
    if (locked_a !== 1'b1) $display("FAIL parity_relock: locked got %b expected 1", locked_a);
    else n_pass++;
  endtask

  task automatic test_reversal_reset();
    int seq[4] = '{4, 6, 8, 6};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, seq[i], 1);
      n_total++;
      if (obs !== exp_vec()) $display("FAIL reversal_model[%0d]: got %h expected %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_total++;
    if ({es_a, locked_a} !== 2'b10) $display("FAIL reversal_hit: got serr=%b locked=%b expected 1 0", es_a, locked_a);
    else n_pass++;
    do_reset();
    n_total++;
    if (obs !== 20'd0) $display("FAIL reversal_reset: got %h expected %h", obs, 20'd0);
    else n_pass++;
    // First sample after reset is a fresh reference: no step error from 6 -> 3.
    drive(1, 3, 0);
    drive(1, 1, 0);
    n_total++;
    if (obs !== exp_vec() || es_a !== 1'b0) $display("FAIL reset_fresh_ref: got %h expected %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [1:0] want2[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2 * i + 1, 1);
      n_total++;
      if ({ec_b, ec_a, ep_a} !== {want2[i], 8'(i + 1), 1'b1})
        $display("FAIL saturate[%0d]: got w2=%0d w8=%0d perr=%b expected %0d %0d 1", i, ec_b, ec_a, ep_a, want2[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int prev, c, r;
    bit e, gdir, v;
    do_reset();
    prev = 0; e = 1; gdir = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 150) == 0) do_reset();
      if ($urandom_range(0, 40) == 0) e = ~e;
      if ($urandom_range(0, 30) == 0) gdir = ~gdir;
      r = $urandom_range(0, 11);
      if (r < 8)        c = (prev + (gdir ? 2 : 14)) % 16;
      else if (r == 8)  c = (prev + (gdir ? 14 : 2)) % 16;
      else if (r == 9)  c = prev;
      else              c = $urandom_range(0, 15);
      v = ($urandom_range(0, 5) != 0);
      drive(v, c, e);
      if (v) prev = c;
      n_total++;
      if (obs !== exp_vec()) $display("FAIL random[%0d] cnt=%0d even=%0b v=%0b: got %h expected %h", i, c, e, v, obs, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_up();
    test_wrap_down();
    test_step_error();
    test_parity();
    test_reversal_reset();
    test_saturate();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/even_odd_seq_checker.md
# even_odd_seq_checker

Monitors the 4-bit stream produced by an even/odd up/down counter and checks that it is a legal sequence: every sample has the selected parity, and successive samples step by exactly ±2 modulo 16 in a constant direction. It sits on the receive side of the counter interface, next to the counter in test and self-check builds. It acquires lock, infers direction, flags parity and step violations, and counts errors.

## Interface
- LOCK_LEN, 2: consecutive legal steps required, after the first reference sample, to assert `locked` (legal range 1..7).
- ERR_W, 8: width of the saturating error counter.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- valid  input  1  `count` carries a sample this cycle.
- count  input  4  counter value under test.
- even  input  1  expected parity: 1 = even (count[0]==0), 0 = odd (count[0]==1).
- locked  output  1  level; sequence acquired and tracking.
- dir  output  1  inferred direction: 1 = up (+2), 0 = down (−2); meaningful only while locked.
- wrap  output  1  one-cycle pulse on a legal step that crosses the 4-bit boundary.
- err_parity  output  1  one-cycle pulse; sample had the wrong parity.
- err_step  output  1  one-cycle pulse; step illegal while in TRACK or LOCKED.
- err_count  output  ERR_W  saturating count of err_parity plus err_step events.

## Operation
- States: IDLE, ACQUIRE, TRACK, LOCKED. Internal registers: `ref` (4 bits), `run` (3 bits), `dir`.
- delta = (count − ref) mod 16. A step is legal-up when delta==2 and legal-down when delta==14. Every other delta, including 0, is illegal.
- Parity is checked on every valid sample, in every state, against the current value of `even`.
- A parity-bad sample pulses err_parity, is never stored as `ref`, and sends the FSM to IDLE. This takes priority over any step evaluation. err_step does not pulse on that cycle.
- IDLE: a good-parity sample loads `ref` and moves to ACQUIRE.
- ACQUIRE:
  - Legal step: set `dir` from delta, run=1, load `ref`, go to TRACK. Go directly to LOCKED if LOCK_LEN==1.
  - Illegal step: load `ref`, stay in ACQUIRE. No err_step.
- TRACK:
  - Step legal in the stored `dir`: run+1 and load `ref`. When run+1==LOCK_LEN, go to LOCKED.
  - Any other step: err_step, load `ref`, go to ACQUIRE.
- LOCKED:
  - Step legal in `dir`: load `ref`, stay in LOCKED.
  - Illegal step or direction reversal: err_step, locked deasserts, load `ref`, go to ACQUIRE.
- wrap fires on a legal step in TRACK or LOCKED when up and count<ref (14→0, 15→1), or when down and count>ref (0→14, 1→15).
- err_count increments by 1 per error cycle and holds at 2^ERR_W−1.
- valid=0: no state change, all pulses 0.

## Timing
- All outputs are registered. A response appears on the cycle after the clk edge that sampled valid. Latency is 1 cycle.
- locked rises 1 cycle after the LOCK_LEN-th legal step and falls 1 cycle after the first error.
- Pulses are exactly one cycle wide. Back-to-back error samples produce back-to-back pulses, and err_count advances each cycle.
- Reset values (reset==0 at an edge): state=IDLE, ref=0, run=0, dir=0, locked=0, wrap=0, err_parity=0, err_step=0, err_count=0. Reset overrides valid on the same edge.
- Reset mid-LOCKED discards all history. The first sample after reset is treated as a fresh reference.
- Toggling `even` mid-stream: the next sample is checked against the new parity. A mismatch takes the parity-error path.

## Test plan
- even=1, valid every cycle, count 0,2,4,6,8 → locked=1 in the cycle after sample 4; dir=1; no errors; err_count=0.
- even=0, locked down on 7,5,3,1, then 15,13 → wrap pulses once, in the cycle after sample 15; locked stays 1; dir=0.
- Locked up on 2,4,6, then 10 → err_step pulses once, locked→0, err_count=1; then 12,14 relocks with LOCK_LEN=2.
- even=1, stream 4,6,7 → err_parity pulse, state IDLE, err_step=0; then 8,10,12 → locked=1.
- Locked up, then 8,6 (reversal) → err_step, locked→0; then reset=0 for one edge → all outputs 0, including err_count.
- ERR_W=2, four consecutive parity-bad samples → err_count reads 1,2,3,3 (saturates).
